data_memory_ls: RTL and testbench

- Parametrised, byte-addressed single-port data memory for the RISC-V datapath; next generation of the word-only instruction/data memory.
- Adds a base-address window, RISC-V load/store sizes (byte/half/word) with sign/zero extension and per-byte write strobes.
- Adds registered one-cycle read latency with a valid strobe, and misalignment/range error reporting.
- Sits between the execute stage (address/store data/funct3) and the writeback mux.

---
 rtl/data_memory_ls.sv | 147 ++++++++++++++
 tb/tb_data_memory_ls.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ls.sv
// data_memory_ls: byte-addressed single-port data memory for the RISC-V datapath.
// Supports a base-address window, RISC-V byte/half/word loads and stores with
// sign/zero extension, per-byte write lanes, a registered one-cycle read with a
// valid strobe, and misalignment/range/funct3 error reporting.
module data_memory_ls #(
    parameter int unsigned         DEPTH     = 256,
    parameter int unsigned         ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       Din,
    output logic [31:0]       out,
    output logic              rvalid,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int unsigned WORD_W = $clog2(DEPTH);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    // Contents are deliberately not reset; only control/output registers are.
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] off;
    logic [WORD_W-1:0] word;
    logic [1:0]        lane;
    logic              illegal;
    logic              out_of_range;
    logic              misaligned;
    logic [1:0]        fault_code;
    logic [3:0]        byte_en;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       load_data;
    logic              do_write;

    // Address decode and fault classification, highest priority first
    always_comb begin
        off          = addr - BASE_ADDR;
        word         = off[WORD_W+1:2];
        lane         = off[1:0];

        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = we;
            default:                illegal = 1'b1;
        endcase

        // BASE_ADDR is window-aligned, so any set bit above the window is out of range
        out_of_range = (addr < BASE_ADDR) || (|off[ADDR_W-1:WORD_W+2]);
        misaligned   = ((funct3[1:0] == 2'b01) && lane[0]) ||
                       ((funct3[1:0] == 2'b10) && (lane != 2'b00));

        if (illegal)           fault_code = ERR_FUNCT3;
        else if (out_of_range) fault_code = ERR_RANGE;
        else if (misaligned)   fault_code = ERR_MISALIGN;
        else                   fault_code = ERR_NONE;
    end

    // Store lane enables; data is replicated so each enabled lane sees its byte
    always_comb begin
        byte_en = '0;
        wr_data = '0;
        case (funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{Din[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{Din[15:0]}};
            end
            default: begin
                byte_en = '1;
                wr_data = Din;
            end
        endcase
        do_write = req && we && (fault_code == ERR_NONE);
    end

    // Load lane selection and extension
    always_comb begin
        rd_word = mem[word];
        case (lane)
            2'd0:    sel_byte = rd_word[7:0];
            2'd1:    sel_byte = rd_word[15:8];
            2'd2:    sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
        sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {24'b0, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  load_data = {16'b0, sel_half};
            default: load_data = rd_word;
        endcase
    end

    // Byte-lane memory write; suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Response registers. Lane select/extension is done before the register
    // rather than after it; the value seen at out one cycle later is identical.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out      <= '0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            rvalid   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            if (req) begin
                if (fault_code != ERR_NONE) begin
                    err      <= 1'b1;
                    err_code <= fault_code;
                    out      <= '0;
                end else if (!we) begin
                    rvalid   <= 1'b1;
                    out      <= load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ls.sv
// Testbench for data_memory_ls: two instances (base 0 / depth 256, and
// base 0x1000 / depth 16), a byte-array reference model checked every cycle,
// and directed loads/faults with literal expected values.
module tb_data_memory_ls;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req    [2];
    logic        we     [2];
    logic [2:0]  f3     [2];
    logic [31:0] addr   [2];
    logic [31:0] din    [2];
    logic [31:0] out    [2];
    logic        rvalid [2];
    logic        err    [2];
    logic [1:0]  ecode  [2];

    logic [7:0]  mm       [2][1024];
    logic [31:0] exp_out  [2];
    logic        exp_rv   [2];
    logic        exp_err  [2];
    logic [1:0]  exp_code [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_ls dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .funct3(f3[0]),
        .addr(addr[0]), .Din(din[0]), .out(out[0]), .rvalid(rvalid[0]),
        .err(err[0]), .err_code(ecode[0])
    );

    data_memory_ls #(.DEPTH(16), .ADDR_W(32), .BASE_ADDR(32'h0000_1000)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .funct3(f3[1]),
        .addr(addr[1]), .Din(din[1]), .out(out[1]), .rvalid(rvalid[1]),
        .err(err[1]), .err_code(ecode[1])
    );

    // Reference model: one request evaluated from the load/store rules on a byte array
    task automatic step(int d);
        logic [31:0] base, off, v, mask;
        int unsigned depth, size;
        logic [1:0]  code;
        if (!req[d]) begin
            exp_rv[d] = 1'b0; exp_err[d] = 1'b0; exp_code[d] = 2'd0;
            return;
        end
        base  = (d == 1) ? 32'h1000 : 32'h0;
        depth = (d == 1) ? 16 : 256;
        off   = addr[d] - base;
        case (f3[d][1:0])
            2'b00:   size = 1;
            2'b01:   size = 2;
            default: size = 4;
        endcase
        if (f3[d] == 3'd3 || f3[d] == 3'd6 || f3[d] == 3'd7 || (we[d] && f3[d][2]))
            code = 2'd3;
        else if (addr[d] < base || off >= depth * 4)
            code = 2'd2;
        else if (off % size != 0)
            code = 2'd1;
        else
            code = 2'd0;
        exp_rv[d] = 1'b0; exp_err[d] = 1'b0; exp_code[d] = code;
        if (code != 2'd0) begin
            exp_err[d] = 1'b1;
            exp_out[d] = 32'h0;
        end else if (we[d]) begin
            for (int unsigned i = 0; i < size; i++)
                mm[d][off + i] = 8'(din[d] >> (8 * i));
        end else begin
            v = 32'h0;
            for (int unsigned i = 0; i < size; i++)
                v |= 32'(mm[d][off + i]) << (8 * i);
            if (size < 4 && !f3[d][2]) begin
                mask = (32'd1 << (8 * size)) - 32'd1;
                if (v[8 * size - 1]) v |= ~mask;
            end
            exp_out[d] = v;
            exp_rv[d]  = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            step(0);
            step(1);
        end
    end

    always @(posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            exp_out[d] = 32'h0; exp_rv[d] = 1'b0; exp_err[d] = 1'b0; exp_code[d] = 2'd0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({out[d], rvalid[d], err[d], ecode[d]} !==
                {exp_out[d], exp_rv[d], exp_err[d], exp_code[d]}) begin
                errors++;
                $display("FAIL model dut%0d @%0t: got out=%h rvalid=%b err=%b code=%b, required out=%h rvalid=%b err=%b code=%b",
                         d, $time, out[d], rvalid[d], err[d], ecode[d],
                         exp_out[d], exp_rv[d], exp_err[d], exp_code[d]);
            end
            checks++;
            if (rvalid[d] === 1'b1 && err[d] === 1'b1) begin
                errors++;
                $display("FAIL exclusive dut%0d @%0t: got rvalid=1 err=1, required not both", d, $time);
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic op(int d, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] dd);
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
        req[d] = 1'b1; we[d] = w; f3[d] = f; addr[d] = a; din[d] = dd;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req[0] = 1'b0; req[1] = 1'b0;
    endtask

    task automatic ld(int d, logic [2:0] f, logic [31:0] a, logic [31:0] expv, string name);
        op(d, 1'b0, f, a, 32'h0);
        idle();
        @(negedge clk); #1;
        chk({name, " out"}, out[d], expv);
        chk({name, " rvalid"}, 32'(rvalid[d]), 32'd1);
    endtask

    task automatic fault(int d, logic w, logic [2:0] f, logic [31:0] a, logic [1:0] code, string name);
        op(d, w, f, a, 32'h0);
        idle();
        @(negedge clk); #1;
        chk({name, " err"}, 32'(err[d]), 32'd1);
        chk({name, " code"}, 32'(ecode[d]), 32'(code));
        chk({name, " rvalid"}, 32'(rvalid[d]), 32'd0);
        chk({name, " out"}, out[d], 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'd0; addr[d] = 32'h0; din[d] = 32'h0;
            exp_out[d] = 32'h0; exp_rv[d] = 1'b0; exp_err[d] = 1'b0; exp_code[d] = 2'd0;
            for (int i = 0; i < 1024; i++) mm[d][i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        #1;
        chk("reset out", out[0], 32'h0);
        chk("reset rvalid", 32'(rvalid[0]), 32'd0);
        chk("reset err", 32'(err[0]), 32'd0);
        chk("reset code", 32'(ecode[0]), 32'd0);
        reset = 1'b0;

        // Word, byte and half stores/loads on the base-0 instance
        op(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        ld(0, 3'd2, 32'h10, 32'hDEADBEEF, "lw 0x10");
        op(0, 1'b1, 3'd0, 32'h11, 32'h000000A5);
        ld(0, 3'd0, 32'h11, 32'hFFFFFFA5, "lb 0x11");
        ld(0, 3'd4, 32'h11, 32'h000000A5, "lbu 0x11");
        ld(0, 3'd2, 32'h10, 32'hDEADA5EF, "lw 0x10 after sb");
        op(0, 1'b1, 3'd1, 32'h22, 32'h00008001);
        ld(0, 3'd1, 32'h22, 32'hFFFF8001, "lh 0x22");
        ld(0, 3'd5, 32'h22, 32'h00008001, "lhu 0x22");
        ld(0, 3'd2, 32'h20, 32'h80010000, "lw 0x20 after sh");
        ld(0, 3'd0, 32'h23, 32'hFFFFFF80, "lb 0x23");

        // Faults and priority
        fault(0, 1'b0, 3'd2, 32'h13, 2'b01, "lw misaligned");
        fault(0, 1'b1, 3'd2, 32'h13, 2'b01, "sw misaligned");
        ld(0, 3'd2, 32'h10, 32'hDEADA5EF, "lw 0x10 after bad sw");
        fault(0, 1'b0, 3'd3, 32'h10, 2'b11, "funct3 011");
        fault(0, 1'b1, 3'd4, 32'h10, 2'b11, "store lbu");
        fault(0, 1'b0, 3'd2, 32'h400, 2'b10, "lw 0x400");
        fault(0, 1'b0, 3'd1, 32'h401, 2'b10, "range over misalign");
        fault(0, 1'b0, 3'd6, 32'h403, 2'b11, "funct3 over range");

        // Top word, output hold, store without rvalid, store-then-load
        op(0, 1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D);
        ld(0, 3'd2, 32'h3FC, 32'hCAFEF00D, "lw 0x3fc");
        idle(); idle();
        @(negedge clk); #1;
        chk("hold out", out[0], 32'hCAFEF00D);
        chk("hold rvalid", 32'(rvalid[0]), 32'd0);
        op(0, 1'b1, 3'd2, 32'h24, 32'h01020304);
        idle();
        @(negedge clk); #1;
        chk("store rvalid", 32'(rvalid[0]), 32'd0);
        chk("store err", 32'(err[0]), 32'd0);
        op(0, 1'b1, 3'd2, 32'h28, 32'hAABBCCDD);
        op(0, 1'b0, 3'd2, 32'h28, 32'h0);
        idle();
        @(negedge clk); #1;
        chk("st->ld out", out[0], 32'hAABBCCDD);

        // Base 0x1000 instance
        op(1, 1'b1, 3'd2, 32'h1000, 32'h11111111);
        op(1, 1'b1, 3'd2, 32'h1004, 32'h22222222);
        op(1, 1'b1, 3'd2, 32'h1008, 32'h33333333);
        op(1, 1'b1, 3'd2, 32'h103C, 32'h44444444);
        fault(1, 1'b0, 3'd2, 32'h0FFC, 2'b10, "below base");
        fault(1, 1'b0, 3'd2, 32'h1040, 2'b10, "past window");
        fault(1, 1'b0, 3'd2, 32'h0, 2'b10, "wrap below base");
        ld(1, 3'd2, 32'h103C, 32'h44444444, "lw 0x103c");
        ld(1, 3'd2, 32'h1000, 32'h11111111, "lw 0x1000");
        op(1, 1'b0, 3'd2, 32'h1000, 32'h0);
        op(1, 1'b0, 3'd2, 32'h1004, 32'h0);
        @(negedge clk); #1;
        chk("b2b 1 out", out[1], 32'h11111111);
        chk("b2b 1 rvalid", 32'(rvalid[1]), 32'd1);
        op(1, 1'b0, 3'd2, 32'h1008, 32'h0);
        @(negedge clk); #1;
        chk("b2b 2 out", out[1], 32'h22222222);
        chk("b2b 2 rvalid", 32'(rvalid[1]), 32'd1);
        idle();
        @(negedge clk); #1;
        chk("b2b 3 out", out[1], 32'h33333333);
        chk("b2b 3 rvalid", 32'(rvalid[1]), 32'd1);
        idle();
        @(negedge clk); #1;
        chk("b2b end rvalid", 32'(rvalid[1]), 32'd0);

        // Asynchronous reset mid-cycle; store and load under reset are dropped
        op(0, 1'b1, 3'd2, 32'h30, 32'h5A5A5A5A);
        op(0, 1'b0, 3'd2, 32'h10, 32'h0);
        op(0, 1'b1, 3'd2, 32'h30, 32'h12345678);
        @(negedge clk); #1;
        chk("pre-reset out", out[0], 32'hDEADA5EF);
        chk("pre-reset rvalid", 32'(rvalid[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async reset out", out[0], 32'h0);
        chk("async reset rvalid", 32'(rvalid[0]), 32'd0);
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; f3[0] = 3'd2; addr[0] = 32'h10;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk); #1;
        chk("reset load dropped", 32'(rvalid[0]), 32'd0);
        chk("reset load out", out[0], 32'h0);
        reset = 1'b0;
        ld(0, 3'd2, 32'h30, 32'h5A5A5A5A, "lw 0x30 after reset");
        ld(0, 3'd2, 32'h10, 32'hDEADA5EF, "lw 0x10 after reset");

        idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
